// File: rtl/rr_arbiter_8_pkg.sv
// -----------------------------------------------------------------------------
// rr_arbiter_8_pkg
// Shared definitions for the 8-way round-robin arbiter:
//   - state_e   : arbiter FSM encoding (IDLE = 0, BUSY = 1)
//   - NUM_REQ   : number of requesters
//   - rr_pick() : round-robin search helper
// -----------------------------------------------------------------------------
package rr_arbiter_8_pkg;

    localparam int NUM_REQ = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Returns the first set request bit found when searching upward from
    // (last + 1) mod 8, wrapping around. The last step of the loop revisits
    // 'last' itself, so the most recent grantee is the lowest-priority
    // candidate. Returns 'last' when no request is set. Callers only use the
    // result when at least one request is set.
    function automatic logic [2:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                           input logic [2:0]         last);
        logic [2:0] idx;
        logic       found;
        rr_pick = last;
        found   = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = last + k[2:0];
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end else begin
                found   = found;
            end
        end
    endfunction

endpackage

// File: rtl/decoder_3_8.sv
// -----------------------------------------------------------------------------
// decoder_3_8
// 3-to-8 one-hot decoder with enable.
//   E   : enable; when 0 the output is all-zero
//   In  : binary index
//   Out : one-hot decode of In when E = 1, else 8'h00
// -----------------------------------------------------------------------------
module decoder_3_8 (
    input  logic       E,
    input  logic [2:0] In,
    output logic [7:0] Out
);

    // One-hot decode, gated by the enable.
    always_comb begin
        Out = 8'h00;
        if (E) begin
            case (In)
                3'd0:    Out = 8'b0000_0001;
                3'd1:    Out = 8'b0000_0010;
                3'd2:    Out = 8'b0000_0100;
                3'd3:    Out = 8'b0000_1000;
                3'd4:    Out = 8'b0001_0000;
                3'd5:    Out = 8'b0010_0000;
                3'd6:    Out = 8'b0100_0000;
                3'd7:    Out = 8'b1000_0000;
                default: Out = 8'h00;
            endcase
        end else begin
            Out = 8'h00;
        end
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// -----------------------------------------------------------------------------
// rr_arbiter_8
// 8-way round-robin arbiter with a maximum grant hold time.
//   clka      : clock, all state updates on the rising edge
//   rst       : synchronous active-high reset, dominates all other inputs
//   req       : request lines, bit i = requester i
//   done      : current grantee releases the resource
//   gnt       : one-hot grant (8'h00 when no grant)
//   gnt_idx   : binary index of the current or most recent grantee
//   gnt_valid : grant active
//   timeout   : one-cycle pulse after a grant is revoked by hold-limit expiry
// Every grant is followed by at least one IDLE cycle, so a lone persistent
// requester is re-granted after a one-cycle gap.
// -----------------------------------------------------------------------------
module rr_arbiter_8
    import rr_arbiter_8_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic       clka,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    // Hold counter value in the final permitted cycle of a grant.
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_e     state_q,    state_d;
    logic [2:0] gnt_idx_q,  gnt_idx_d;
    logic [2:0] last_idx_q, last_idx_d;
    logic [7:0] hold_q,     hold_d;
    logic       timeout_q,  timeout_d;
    logic [2:0] pick_s;

    assign pick_s = rr_pick(req, last_idx_q);

    // Next-state logic: grant selection in IDLE, release and hold limit in BUSY.
    always_comb begin
        state_d    = state_q;
        gnt_idx_d  = gnt_idx_q;
        last_idx_d = last_idx_q;
        hold_d     = hold_q;
        timeout_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req != 8'h00) begin
                    state_d    = BUSY;
                    gnt_idx_d  = pick_s;
                    last_idx_d = pick_s;
                    hold_d     = 8'd0;
                end else begin
                    state_d    = IDLE;
                end
            end
            BUSY: begin
                // done and request drop take priority over the hold limit,
                // so a timeout is only flagged when the limit alone ends the grant.
                if (done || !req[gnt_idx_q]) begin
                    state_d   = IDLE;
                    hold_d    = 8'd0;
                    timeout_d = 1'b0;
                end else if (hold_q == HOLD_LAST) begin
                    state_d   = IDLE;
                    hold_d    = 8'd0;
                    timeout_d = 1'b1;
                end else begin
                    hold_d    = hold_q + 8'd1;
                end
            end
            default: begin
                state_d   = IDLE;
                hold_d    = 8'd0;
                timeout_d = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset; last_idx resets to 7 so that
    // requester 0 has first priority.
    always_ff @(posedge clka) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_idx_q  <= 3'd0;
            last_idx_q <= 3'd7;
            hold_q     <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_idx_q  <= gnt_idx_d;
            last_idx_q <= last_idx_d;
            hold_q     <= hold_d;
            timeout_q  <= timeout_d;
        end
    end

    assign gnt_valid = (state_q == BUSY);
    assign gnt_idx   = gnt_idx_q;
    assign timeout   = timeout_q;

    decoder_3_8 u_gnt_dec (
        .E   (gnt_valid),
        .In  (gnt_idx_q),
        .Out (gnt)
    );

endmodule

// File: doc/rr_arbiter_8.md
RR_ARBITER_8 -- requirements
Module: rr_arbiter_8

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 8, meaning the maximum number of cycles one grant is held (legal range 2..255).
REQ-002 SHALL have port clka  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req  input  8  request lines, bit i is requester i.
REQ-005 SHALL have port done  input  1  the current grantee releases the resource.
REQ-006 SHALL have port gnt  output  8  one-hot grant, all-zero when no grant.
REQ-007 SHALL have port gnt_idx  output  3  binary index of the current or most recent grantee.
REQ-008 SHALL have port gnt_valid  output  1  grant active.
REQ-009 SHALL have port timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD expiry.

Function
REQ-010 SHALL implement a two-state FSM: IDLE (no grant) and BUSY (grant held).
REQ-011 In IDLE with req != 0, SHALL select the first set req bit searching from (last_idx+1) mod 8 upward with wrap-around, register it into gnt_idx, and enter BUSY; gnt_valid SHALL rise on the cycle after req is sampled (latency 1).
REQ-012 In IDLE with req == 0, SHALL remain in IDLE with gnt_valid=0.
REQ-013 On entry to BUSY, SHALL set last_idx to the new gnt_idx and clear the hold counter to 0.
REQ-014 In BUSY, hold counter SHALL increment by 1 each cycle; 8-bit width; it never wraps because of REQ-015.
REQ-015 BUSY SHALL exit to IDLE at the end of the cycle in which any of the following holds: done=1; req[gnt_idx]=0; hold counter == MAX_HOLD-1.
REQ-016 timeout SHALL be 1 for exactly the cycle after an exit caused solely by the hold limit (done=0 and req[gnt_idx]=1); priority: done, then request drop, then timeout.
REQ-017 After any BUSY exit, gnt_valid SHALL be 0 for at least one cycle before the next grant.
REQ-018 Requests changing during BUSY SHALL NOT alter gnt_idx or gnt.
REQ-019 gnt SHALL equal one-hot decode of gnt_idx when gnt_valid=1, else 8'h00; gnt SHALL never have more than one bit set.
REQ-020 gnt_idx SHALL hold its last value in IDLE.
REQ-021 A single persistent requester SHALL be re-granted after its one-cycle IDLE gap (no starvation of a lone requester).

Reset
REQ-022 While rst=1 at a clka edge: state=IDLE, gnt_valid=0, gnt=8'h00, gnt_idx=3'd0, timeout=0, hold counter=0, last_idx=3'd7 (so requester 0 has first priority).
REQ-023 rst asserted during BUSY SHALL drop the grant on the next edge with no timeout pulse.
REQ-024 rst SHALL dominate every other input on the same cycle.

Structure
REQ-025 Shared package SHALL hold the FSM state encoding (IDLE=0, BUSY=1) and the constant NUM_REQ=8.
REQ-026 The one-hot gnt SHALL come from one instance of the team's existing decoder_3_8, with E driven by gnt_valid, In by gnt_idx, Out by gnt; no other sub-modules.

Verification
REQ-027 Reset then req=8'hFF held, done=0 -> grants in order 0,1,2,...,7,0, each lasting MAX_HOLD cycles with timeout pulse after each, one idle cycle between.
REQ-028 After reset, req=8'b0010_0100 -> gnt=8'h04 one cycle later; done pulse -> gnt=8'h00 for one cycle, then gnt=8'h20.
REQ-029 Grant to requester 5, then req[5] dropped -> gnt_valid=0 next cycle, timeout stays 0; last_idx=5 so with req=8'h21 the next grant is 0.
REQ-030 req=8'h01 only, done never -> grant 0 for MAX_HOLD cycles, timeout pulse, one idle cycle, grant 0 again.
REQ-031 rst asserted mid-BUSY with req=8'hFF -> gnt=8'h00, gnt_idx=0, timeout=0 next cycle; after release, first grant goes to 0.
REQ-032 Every cycle the bench SHALL check $onehot0(gnt) and gnt == (gnt_valid ? 1<<gnt_idx : 0).
